// File: rtl/internal_framebuffer_stream_loader_pkg.sv
// Shared definitions for the internal framebuffer loader and command handler.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   fb_load_state_t          - loader FSM encoding (IDLE, LOAD, DRAIN, DONE)
//   fb_mem_mask_width(...)   - sub-pixel mask bits per RAM word
//   fb_mem_width(...)        - data bits per RAM word
//   fb_ppb_lg(...)           - log2 of pixels per beat
//   fb_mem_addr_width(...)   - RAM beat-address width
package internal_framebuffer_stream_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fb_load_state_t;

  // One mask bit per sub-pixel of every pixel in a RAM word.
  function automatic int fb_mem_mask_width(input int pixels_per_beat, input int sub_pixels);
    return pixels_per_beat * sub_pixels;
  endfunction

  function automatic int fb_mem_width(input int pixels_per_beat, input int sub_pixels,
                                      input int sub_pixel_width);
    return pixels_per_beat * sub_pixels * sub_pixel_width;
  endfunction

  function automatic int fb_ppb_lg(input int pixels_per_beat);
    return $clog2(pixels_per_beat);
  endfunction

  // The RAM is addressed in whole beats, so the pixel-index bits inside a
  // beat are dropped from the address.
  function automatic int fb_mem_addr_width(input int fb_size_in_pixel_lg, input int pixels_per_beat);
    return fb_size_in_pixel_lg - $clog2(pixels_per_beat);
  endfunction

endpackage

// File: rtl/internal_framebuffer_stream_loader_write_stage.sv
// One-cycle register between an accepted stream beat and the RAM write port.
// Latency: 1 cycle from beat_write to writeEnablePort.
// Backpressure: none; accepts a write every cycle.
//
// Ports:
//   aclk, resetn     clock, synchronous active-low reset (clears only the enable)
//   beat_write       write this beat next cycle
//   beat_addr/data   RAM beat address and pixel data for the beat
//   beat_strb        per-sub-pixel stream strobe
//   conf_mask        per-sub-pixel enable, applied to every pixel of the beat
//   write*Port       registered RAM write port
import internal_framebuffer_stream_loader_pkg::*;

module internal_framebuffer_stream_loader_write_stage #(
  parameter int NUMBER_OF_PIXELS_PER_BEAT = 2,
  parameter int NUMBER_OF_SUB_PIXELS      = 4,
  parameter int SUB_PIXEL_WIDTH           = 8,
  parameter int ADDR_WIDTH                = 17
) (
  input  logic                                  aclk,
  input  logic                                  resetn,
  input  logic                                  beat_write,
  input  logic [ADDR_WIDTH-1:0]                 beat_addr,
  input  logic [fb_mem_width(NUMBER_OF_PIXELS_PER_BEAT, NUMBER_OF_SUB_PIXELS,
                             SUB_PIXEL_WIDTH)-1:0] beat_data,
  input  logic [fb_mem_mask_width(NUMBER_OF_PIXELS_PER_BEAT,
                                  NUMBER_OF_SUB_PIXELS)-1:0] beat_strb,
  input  logic [NUMBER_OF_SUB_PIXELS-1:0]       conf_mask,
  output logic [fb_mem_width(NUMBER_OF_PIXELS_PER_BEAT, NUMBER_OF_SUB_PIXELS,
                             SUB_PIXEL_WIDTH)-1:0] writeDataPort,
  output logic                                  writeEnablePort,
  output logic [ADDR_WIDTH-1:0]                 writeAddrPort,
  output logic [fb_mem_mask_width(NUMBER_OF_PIXELS_PER_BEAT,
                                  NUMBER_OF_SUB_PIXELS)-1:0] writeMaskPort
);

  localparam int MEM_MASK_WIDTH = fb_mem_mask_width(NUMBER_OF_PIXELS_PER_BEAT, NUMBER_OF_SUB_PIXELS);

  logic [MEM_MASK_WIDTH-1:0] beat_mask;

  // confMask is per sub-pixel; replicate it across every pixel of the beat.
  assign beat_mask = beat_strb & {NUMBER_OF_PIXELS_PER_BEAT{conf_mask}};

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      writeEnablePort <= 1'b0;
    end else begin
      writeEnablePort <= beat_write;
    end
    // Payload registers only matter when the enable is high, so they are
    // left out of reset and only load on a real write.
    if (beat_write) begin
      writeAddrPort <= beat_addr;
      writeDataPort <= beat_data;
      writeMaskPort <= beat_mask;
    end
  end

endmodule

// File: rtl/internal_framebuffer_stream_loader.sv
// Loads an AXI-Stream of pixel beats linearly into the framebuffer RAM from beat address 0.
// Latency: 1 cycle from accepted beat to RAM write; 1 beat/cycle throughput.
// Backpressure: none while loading; tready drops only when idle or once the load has ended.
//
// Ports:
//   aclk, resetn        clock, synchronous active-low reset
//   confMask            per-sub-pixel write enable, sampled on every beat
//   apply/applied       command handshake shared with the framebuffer command handler
//   cmdLoad, cmdSize    load command select and transfer size in pixels
//   s_axis_*            pixel beat stream (pixel 0 in the LSBs of tdata)
//   write*Port          RAM write port
//   statusShort/Long    sticky: stream ended early / stream overran cmdSize
import internal_framebuffer_stream_loader_pkg::*;

module internal_framebuffer_stream_loader #(
  parameter int NUMBER_OF_PIXELS_PER_BEAT    = 2,
  parameter int NUMBER_OF_SUB_PIXELS         = 4,
  parameter int SUB_PIXEL_WIDTH              = 8,
  parameter int FRAMEBUFFER_SIZE_IN_PIXEL_LG = 18,
  parameter int FB_SIZE_IN_PIXEL_LG          = 20,
  localparam int MEM_MASK_WIDTH = fb_mem_mask_width(NUMBER_OF_PIXELS_PER_BEAT, NUMBER_OF_SUB_PIXELS),
  localparam int MEM_WIDTH      = fb_mem_width(NUMBER_OF_PIXELS_PER_BEAT, NUMBER_OF_SUB_PIXELS,
                                               SUB_PIXEL_WIDTH),
  localparam int PPB_LG         = fb_ppb_lg(NUMBER_OF_PIXELS_PER_BEAT),
  localparam int MEM_ADDR_WIDTH = fb_mem_addr_width(FRAMEBUFFER_SIZE_IN_PIXEL_LG,
                                                    NUMBER_OF_PIXELS_PER_BEAT)
) (
  input  logic                            aclk,
  input  logic                            resetn,
  input  logic [NUMBER_OF_SUB_PIXELS-1:0] confMask,
  input  logic                            apply,
  output logic                            applied,
  input  logic                            cmdLoad,
  input  logic [FB_SIZE_IN_PIXEL_LG-1:0]  cmdSize,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  input  logic [MEM_WIDTH-1:0]            s_axis_tdata,
  input  logic [MEM_MASK_WIDTH-1:0]       s_axis_tstrb,
  output logic [MEM_WIDTH-1:0]            writeDataPort,
  output logic                            writeEnablePort,
  output logic [MEM_ADDR_WIDTH-1:0]       writeAddrPort,
  output logic [MEM_MASK_WIDTH-1:0]       writeMaskPort,
  output logic                            statusShort,
  output logic                            statusLong
);

  fb_load_state_t            state;
  logic [MEM_ADDR_WIDTH-1:0] beat_idx;
  logic [MEM_ADDR_WIDTH-1:0] beat_idx_nxt;
  logic [MEM_ADDR_WIDTH-1:0] size_beats;
  logic [MEM_ADDR_WIDTH-1:0] cmd_size_beats;
  logic                      beat_accept;
  logic                      beat_write;
  logic                      cmd_size_unused;

  // The sub-beat remainder and any bits above the RAM size are dropped, so
  // the largest load is 2^MEM_ADDR_WIDTH-1 beats.
  assign cmd_size_beats  = cmdSize[PPB_LG +: MEM_ADDR_WIDTH];
  assign cmd_size_unused = ^cmdSize;

  assign beat_accept  = s_axis_tvalid && s_axis_tready;
  // Beats accepted in DRAIN are swallowed; only LOAD beats reach the RAM.
  assign beat_write   = (state == LOAD) && beat_accept;
  // Natural wrap modulo 2^MEM_ADDR_WIDTH.
  assign beat_idx_nxt = beat_idx + MEM_ADDR_WIDTH'(1);

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state         <= IDLE;
      applied       <= 1'b1;
      s_axis_tready <= 1'b0;
      statusShort   <= 1'b0;
      statusLong    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          s_axis_tready <= 1'b0;
          if (apply && cmdLoad) begin
            applied     <= 1'b0;
            beat_idx    <= '0;
            size_beats  <= cmd_size_beats;
            statusShort <= 1'b0;
            statusLong  <= 1'b0;
            if (cmd_size_beats == '0) begin
              state <= DONE;
            end else begin
              state         <= LOAD;
              s_axis_tready <= 1'b1;
            end
          end else if (!apply) begin
            // Held low while apply stays asserted so the requester sees a
            // clean handshake; non-load commands leave it untouched.
            applied <= 1'b1;
          end
        end

        LOAD: begin
          if (beat_accept) begin
            beat_idx <= beat_idx_nxt;
            if (beat_idx_nxt == size_beats) begin
              if (s_axis_tlast) begin
                s_axis_tready <= 1'b0;
                state         <= DONE;
              end else begin
                // Keep tready high and discard the rest of the packet so the
                // upstream stream is not left stalled mid-packet.
                statusLong <= 1'b1;
                state      <= DRAIN;
              end
            end else if (s_axis_tlast) begin
              statusShort   <= 1'b1;
              s_axis_tready <= 1'b0;
              state         <= DONE;
            end
          end
        end

        DRAIN: begin
          if (beat_accept && s_axis_tlast) begin
            s_axis_tready <= 1'b0;
            state         <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  internal_framebuffer_stream_loader_write_stage #(
    .NUMBER_OF_PIXELS_PER_BEAT (NUMBER_OF_PIXELS_PER_BEAT),
    .NUMBER_OF_SUB_PIXELS      (NUMBER_OF_SUB_PIXELS),
    .SUB_PIXEL_WIDTH           (SUB_PIXEL_WIDTH),
    .ADDR_WIDTH                (MEM_ADDR_WIDTH)
  ) u_write_stage (
    .aclk            (aclk),
    .resetn          (resetn),
    .beat_write      (beat_write),
    .beat_addr       (beat_idx),
    .beat_data       (s_axis_tdata),
    .beat_strb       (s_axis_tstrb),
    .conf_mask       (confMask),
    .writeDataPort   (writeDataPort),
    .writeEnablePort (writeEnablePort),
    .writeAddrPort   (writeAddrPort),
    .writeMaskPort   (writeMaskPort)
  );

endmodule

// File: tb/tb_internal_framebuffer_stream_loader.sv
// Testbench for internal_framebuffer_stream_loader: cycle-accurate vector
// table plus a random-data streamed load checked against a small model.
module tb_internal_framebuffer_stream_loader;

  logic        aclk;
  logic        resetn;
  logic [3:0]  confMask;
  logic        apply;
  logic        applied;
  logic        cmdLoad;
  logic [19:0] cmdSize;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tstrb;
  logic [63:0] writeDataPort;
  logic        writeEnablePort;
  logic [16:0] writeAddrPort;
  logic [7:0]  writeMaskPort;
  logic        statusShort;
  logic        statusLong;

  internal_framebuffer_stream_loader dut (
    .aclk            (aclk),
    .resetn          (resetn),
    .confMask        (confMask),
    .apply           (apply),
    .applied         (applied),
    .cmdLoad         (cmdLoad),
    .cmdSize         (cmdSize),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tstrb    (s_axis_tstrb),
    .writeDataPort   (writeDataPort),
    .writeEnablePort (writeEnablePort),
    .writeAddrPort   (writeAddrPort),
    .writeMaskPort   (writeMaskPort),
    .statusShort     (statusShort),
    .statusLong      (statusLong)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // One record per clock: inputs driven before the edge, outputs expected after it.
  typedef struct {
    logic        rst_n;
    logic        ap;
    logic        ld;
    logic [19:0] sz;
    logic        vld;
    logic        last;
    logic [63:0] dat;
    logic [7:0]  strb;
    logic [3:0]  cm;
    logic        e_we;
    logic [16:0] e_addr;
    logic [63:0] e_dat;
    logic [7:0]  e_mask;
    logic        e_rdy;
    logic        e_applied;
    logic        e_short;
    logic        e_long;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  function automatic logic [63:0] dv(input int k);
    return {8{8'(k + 16)}} ^ 64'hF0E1_D2C3_B4A5_9687;
  endfunction

  task automatic add(input logic rst_n, input logic ap, input logic ld, input logic [19:0] sz,
                     input logic vld, input logic last, input logic [63:0] dat,
                     input logic [7:0] strb, input logic [3:0] cm,
                     input logic e_we, input logic [16:0] e_addr, input logic [63:0] e_dat,
                     input logic [7:0] e_mask, input logic e_rdy, input logic e_applied,
                     input logic e_short, input logic e_long);
    vec_t v;
    v.rst_n = rst_n; v.ap = ap; v.ld = ld; v.sz = sz; v.vld = vld; v.last = last;
    v.dat = dat; v.strb = strb; v.cm = cm; v.e_we = e_we; v.e_addr = e_addr;
    v.e_dat = e_dat; v.e_mask = e_mask; v.e_rdy = e_rdy; v.e_applied = e_applied;
    v.e_short = e_short; v.e_long = e_long;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin : main
    vec_t        v;
    logic [93:0] obs;
    logic [93:0] exp;
    int          sent;
    int          cyc;
    logic        acc;
    logic        done_seq;
    logic [16:0] exp_addr;
    logic [63:0] exp_dat;
    logic [7:0]  exp_mask;

    checks = 0;
    errors = 0;

    // rst ap ld sz | vld last dat strb cm | we addr dat mask | rdy applied short long
    // Reset state.
    add(0, 0, 0, 0, 0, 0, 64'h0, 8'h00, 4'hF, 0, 0, 64'h0, 8'h00, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 64'h0, 8'h00, 4'hF, 0, 0, 64'h0, 8'h00, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 64'h0, 8'h00, 4'hF, 0, 0, 64'h0, 8'h00, 0, 1, 0, 0);
    // Exact-length load: 4 beats back to back.
    add(1, 1, 1, 8, 0, 0, 64'h0,  8'hFF, 4'hF, 0, 0, 64'h0,  8'h00, 1, 0, 0, 0);
    add(1, 0, 0, 8, 1, 0, dv(0), 8'hFF, 4'hF, 1, 0, dv(0), 8'hFF, 1, 0, 0, 0);
    add(1, 0, 0, 8, 1, 0, dv(1), 8'hFF, 4'hF, 1, 1, dv(1), 8'hFF, 1, 0, 0, 0);
    add(1, 0, 0, 8, 1, 0, dv(2), 8'hFF, 4'hF, 1, 2, dv(2), 8'hFF, 1, 0, 0, 0);
    add(1, 0, 0, 8, 1, 1, dv(3), 8'hFF, 4'hF, 1, 3, dv(3), 8'hFF, 0, 0, 0, 0);
    add(1, 0, 0, 8, 0, 0, 64'h0,  8'hFF, 4'hF, 0, 0, 64'h0,  8'h00, 0, 0, 0, 0);
    add(1, 0, 0, 8, 0, 0, 64'h0,  8'hFF, 4'hF, 0, 0, 64'h0,  8'h00, 0, 1, 0, 0);
    // Gapped valid with confMask 0111 and tstrb F0 -> mask 70.
    add(1, 1, 1, 8, 0, 0, 64'h0,   8'hF0, 4'h7, 0, 0, 64'h0,   8'h00, 1, 0, 0, 0);
    add(1, 0, 0, 8, 1, 0, dv(10), 8'hF0, 4'h7, 1, 0, dv(10), 8'h70, 1, 0, 0, 0);
    add(1, 0, 0, 8, 0, 0, dv(10), 8'hF0, 4'h7, 0, 0, 64'h0,   8'h00, 1, 0, 0, 0);
    add(1, 0, 0, 8, 1, 0, dv(11), 8'hF0, 4'h7, 1, 1, dv(11), 8'h70, 1, 0, 0, 0);
    add(1, 0, 0, 8, 0, 0, dv(11), 8'hF0, 4'h7, 0, 0, 64'h0,   8'h00, 1, 0, 0, 0);
    add(1, 0, 0, 8, 1, 0, dv(12), 8'hF0, 4'h7, 1, 2, dv(12), 8'h70, 1, 0, 0, 0);
    add(1, 0, 0, 8, 0, 0, dv(12), 8'hF0, 4'h7, 0, 0, 64'h0,   8'h00, 1, 0, 0, 0);
    add(1, 0, 0, 8, 1, 1, dv(13), 8'hF0, 4'h7, 1, 3, dv(13), 8'h70, 0, 0, 0, 0);
    add(1, 0, 0, 8, 0, 0, 64'h0,   8'hF0, 4'h7, 0, 0, 64'h0,   8'h00, 0, 0, 0, 0);
    add(1, 0, 0, 8, 0, 0, 64'h0,   8'hF0, 4'h7, 0, 0, 64'h0,   8'h00, 0, 1, 0, 0);
    // Short stream: tlast on beat 2 of 4; confMask changes per beat.
    add(1, 1, 1, 8, 0, 0, 64'h0,   8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 1, 0, 0, 0);
    add(1, 0, 0, 8, 1, 0, dv(20), 8'hFF, 4'hF, 1, 0, dv(20), 8'hFF, 1, 0, 0, 0);
    add(1, 0, 0, 8, 1, 1, dv(21), 8'hFF, 4'h8, 1, 1, dv(21), 8'h88, 0, 0, 1, 0);
    add(1, 0, 0, 8, 1, 0, dv(22), 8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 0, 0, 1, 0);
    add(1, 0, 0, 8, 0, 0, 64'h0,   8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 0, 1, 1, 0);
    add(1, 0, 0, 8, 1, 0, dv(22), 8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 0, 1, 1, 0);
    // Long stream: 2-beat command, 5 beats sent; beats 3..5 drained.
    add(1, 1, 1, 4, 0, 0, 64'h0,   8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 1, 0, 0, 0);
    add(1, 0, 0, 4, 1, 0, dv(30), 8'h0F, 4'hF, 1, 0, dv(30), 8'h0F, 1, 0, 0, 0);
    add(1, 0, 0, 4, 1, 0, dv(31), 8'hFF, 4'hF, 1, 1, dv(31), 8'hFF, 1, 0, 0, 1);
    add(1, 0, 0, 4, 1, 0, dv(32), 8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 1, 0, 0, 1);
    add(1, 0, 0, 4, 1, 0, dv(33), 8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 1, 0, 0, 1);
    add(1, 0, 0, 4, 1, 1, dv(34), 8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 0, 0, 0, 1);
    add(1, 0, 0, 4, 0, 0, 64'h0,   8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 0, 0, 0, 1);
    add(1, 0, 0, 4, 0, 0, 64'h0,   8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 0, 1, 0, 1);
    // Zero size (1 pixel < 1 beat): straight to DONE, tready never rises.
    add(1, 1, 1, 1, 1, 0, dv(40), 8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, dv(40), 8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, dv(40), 8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 0, 1, 0, 0);
    // apply without cmdLoad is ignored.
    add(1, 1, 0, 8, 1, 0, dv(41), 8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 0, 1, 0, 0);
    add(1, 1, 0, 8, 1, 0, dv(41), 8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 0, 1, 0, 0);
    add(1, 0, 0, 8, 0, 0, 64'h0,   8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 0, 1, 0, 0);
    // Reset after beat 1 of 4: pending write dropped.
    add(1, 1, 1, 8, 0, 0, 64'h0,   8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 1, 0, 0, 0);
    add(1, 0, 0, 8, 1, 0, dv(50), 8'hFF, 4'hF, 1, 0, dv(50), 8'hFF, 1, 0, 0, 0);
    add(0, 0, 0, 8, 1, 0, dv(51), 8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 0, 1, 0, 0);
    add(1, 0, 0, 8, 0, 0, 64'h0,   8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 0, 1, 0, 0);
    // Reset while draining clears statusLong.
    add(1, 1, 1, 2, 0, 0, 64'h0,   8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 1, 0, 0, 0);
    add(1, 0, 0, 2, 1, 0, dv(60), 8'hFF, 4'hF, 1, 0, dv(60), 8'hFF, 1, 0, 0, 1);
    add(0, 0, 0, 2, 1, 0, dv(61), 8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 0, 1, 0, 0);
    add(1, 0, 0, 2, 0, 0, 64'h0,   8'hFF, 4'hF, 0, 0, 64'h0,   8'h00, 0, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      v             = vecs[i];
      resetn        = v.rst_n;
      apply         = v.ap;
      cmdLoad       = v.ld;
      cmdSize       = v.sz;
      s_axis_tvalid = v.vld;
      s_axis_tlast  = v.last;
      s_axis_tdata  = v.dat;
      s_axis_tstrb  = v.strb;
      confMask      = v.cm;
      @(negedge aclk);
      obs = {writeEnablePort, s_axis_tready, applied, statusShort, statusLong,
             writeEnablePort ? writeAddrPort : 17'h0,
             writeEnablePort ? writeDataPort : 64'h0,
             writeEnablePort ? writeMaskPort : 8'h0};
      exp = {v.e_we, v.e_rdy, v.e_applied, v.e_short, v.e_long,
             v.e_we ? v.e_addr : 17'h0,
             v.e_we ? v.e_dat : 64'h0,
             v.e_we ? v.e_mask : 8'h0};
      check($sformatf("vec%0d", i), 128'(obs), 128'(exp));
    end

    // Streamed 6-beat load with random gaps, data, strobes and confMask.
    apply         = 1'b1;
    cmdLoad       = 1'b1;
    cmdSize       = 20'd12;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    @(negedge aclk);
    apply    = 1'b0;
    cmdLoad  = 1'b0;
    sent     = 0;
    cyc      = 0;
    done_seq = 1'b0;
    exp_addr = '0;
    exp_dat  = '0;
    exp_mask = '0;
    while (!done_seq && cyc < 200) begin
      acc = 1'b0;
      if (sent < 6 && $urandom_range(0, 2) != 0) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {$urandom(), $urandom()};
        s_axis_tstrb  = 8'($urandom_range(0, 255));
        confMask      = 4'($urandom_range(0, 15));
        s_axis_tlast  = (sent == 5);
        if (s_axis_tready) begin
          acc      = 1'b1;
          exp_addr = 17'(sent);
          exp_dat  = s_axis_tdata;
          exp_mask = s_axis_tstrb & {2{confMask}};
          sent++;
        end
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      @(negedge aclk);
      cyc++;
      if (acc) begin
        check($sformatf("stream_wr%0d", exp_addr),
              128'({writeEnablePort, writeAddrPort, writeDataPort, writeMaskPort}),
              128'({1'b1, exp_addr, exp_dat, exp_mask}));
      end else begin
        check("stream_no_wr", 128'(writeEnablePort), 128'(1'b0));
        if (sent == 6) done_seq = 1'b1;
      end
    end
    check("stream_timeout", 128'(done_seq), 128'(1'b1));
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    for (int k = 0; k < 10 && !applied; k++) @(negedge aclk);
    check("stream_end", 128'({applied, s_axis_tready, statusShort, statusLong}),
          128'(4'b1000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
